// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM state type and baud-divisor helper for the
// UART transmitter.
package uart_pkg;

    // Parity modes.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Transmit FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } tx_state_e;

    // Clock cycles per bit. Integer division truncates the same way the
    // board-level baud tables do.
    function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: valid/ready word handshake into the UART transmitter.
// The master pushes words, the slave (transmitter) signals when it can take one.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous first-word-fall-through FIFO with wrap-bit
// pointers. Only built when UART_TX_FIFO_EN is defined; without it the
// transmitter uses a single holding register instead.
`ifdef UART_TX_FIFO_EN
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    // Pointer advance; the caller never pushes when full nor pops when empty.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk_i) begin
        // NOTE: storage has no reset; empty/full come from the pointers, so stale contents are never read.
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule
`endif

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter (start, DATA_BITS LSB first,
// optional parity, STOP_BITS stop bits) with a valid/ready input and
// zero-gap back-to-back frames. Define UART_TX_FIFO_EN to buffer words in a
// FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    uart_tx_frame_if.slave tx_if,
    output logic           txd,
    output logic           tx_busy
);
    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    // Reject configurations the datapath cannot represent. The FIFO depth is
    // validated in both builds so flipping the FIFO option never surprises.
    generate
        if (BAUD_DIV < 2) begin : g_err_baud
            $error("uart_tx_frame: CLK_FREQ/BAUD_RATE must be >= 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data
            $error("uart_tx_frame: DATA_BITS must be 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
            $error("uart_tx_frame: STOP_BITS must be 1..2");
        end
        if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_err_par
            $error("uart_tx_frame: PARITY must be 0, 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
            $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    // Word buffer between the handshake and the shifter.
    logic                 push;
    logic                 pop;
    logic                 buf_empty;
    logic                 buf_full;
    logic [DATA_BITS-1:0] buf_data;

    assign tx_if.tx_ready = !buf_full && sys_rst_n;
    assign push           = tx_if.tx_valid && tx_if.tx_ready;

`ifdef UART_TX_FIFO_EN
    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_n_i (sys_rst_n),
        .push_i  (push),
        .din_i   (tx_if.tx_data),
        .pop_i   (pop),
        .dout_o  (buf_data),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );
`else
    logic                 hold_valid_q;
    logic                 hold_valid_d;
    logic [DATA_BITS-1:0] hold_data_q;

    // Holding-register occupancy: set on accept, cleared on pop. A full
    // register blocks accepts, so both never coincide here.
    always_comb begin
        hold_valid_d = hold_valid_q;
        if (push)     hold_valid_d = 1'b1;
        else if (pop) hold_valid_d = 1'b0;
    end

    // Occupancy flag with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) hold_valid_q <= 1'b0;
        else            hold_valid_q <= hold_valid_d;
    end

    // Captured word; only read while the occupancy flag is set.
    always_ff @(posedge sys_clk) begin
        if (push) hold_data_q <= tx_if.tx_data;
    end

    assign buf_data  = hold_data_q;
    assign buf_full  = hold_valid_q;
    assign buf_empty = !hold_valid_q;
`endif

    // Transmit FSM and datapath registers.
    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic                 bit_end;

    assign bit_end = (baud_cnt_q == CNT_W'(BAUD_DIV - 1));

    // Next state, counters, shifter and the registered line value.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!buf_empty) begin
                    pop     = 1'b1;
                    shift_d = buf_data;
                    par_d   = (^buf_data) ^ (PARITY == PAR_ODD);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    shift_d    = shift_q >> 1;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            ST_PAR: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_STOP;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        // Last cycle of the last stop bit: chain straight into
                        // the next start bit when a word is waiting.
                        bit_cnt_d = '0;
                        if (!buf_empty) begin
                            pop     = 1'b1;
                            shift_d = buf_data;
                            par_d   = (^buf_data) ^ (PARITY == PAR_ODD);
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line value for the state being entered, so txd is a clean flop.
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
            ST_PAR:   txd_d = par_d;
            default:  txd_d = 1'b1;
        endcase
    end

    // State register; reset aborts any frame and forces the line idle.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            txd_q      <= txd_d;
        end
    end

    assign txd     = txd_q;
    assign tx_busy = (state_q != ST_IDLE) || !buf_empty;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: four transmitters (8N1, 8E1, 8O1, 7N2) at BAUD_DIV=10.
// Stimulus pushes hand-computed frame patterns and start cycles into
// per-instance queues; one monitor per instance pops and compares each frame
// sample by sample as it appears on txd.
module tb_uart_tx_frame;
    import uart_pkg::*;

    localparam int BD = 10;

    typedef struct packed {
        logic [12:0] bits;   // frame bits, bit 0 = start bit
        logic [3:0]  nbits;  // bits in the frame
        logic [31:0] start;  // cycle of the first start-bit sample
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_miss = 0;
    logic [8:0] drv_data [4];
    logic [3:0] drv_valid = '0;
    wire  [3:0] ready_w;
    wire  [3:0] txd_w;
    wire  [3:0] busy_w;
    exp_t       exp_q [4][$];
    int         last_end [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
    uart_tx_frame_if #(.DATA_BITS(8)) if1 ();
    uart_tx_frame_if #(.DATA_BITS(8)) if2 ();
    uart_tx_frame_if #(.DATA_BITS(7)) if3 ();

    assign if0.tx_data  = drv_data[0][7:0];
    assign if1.tx_data  = drv_data[1][7:0];
    assign if2.tx_data  = drv_data[2][7:0];
    assign if3.tx_data  = drv_data[3][6:0];
    assign if0.tx_valid = drv_valid[0];
    assign if1.tx_valid = drv_valid[1];
    assign if2.tx_valid = drv_valid[2];
    assign if3.tx_valid = drv_valid[3];
    assign ready_w[0]   = if0.tx_ready;
    assign ready_w[1]   = if1.tx_ready;
    assign ready_w[2]   = if2.tx_ready;
    assign ready_w[3]   = if3.tx_ready;

    uart_tx_frame #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(8),
                    .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4))
        dut0 (.sys_clk(clk), .sys_rst_n(rst_n), .tx_if(if0), .txd(txd_w[0]), .tx_busy(busy_w[0]));
    uart_tx_frame #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(8),
                    .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4))
        dut1 (.sys_clk(clk), .sys_rst_n(rst_n), .tx_if(if1), .txd(txd_w[1]), .tx_busy(busy_w[1]));
    uart_tx_frame #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(8),
                    .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(4))
        dut2 (.sys_clk(clk), .sys_rst_n(rst_n), .tx_if(if2), .txd(txd_w[2]), .tx_busy(busy_w[2]));
    uart_tx_frame #(.CLK_FREQ(50_000_000), .BAUD_RATE(5_000_000), .DATA_BITS(7),
                    .PARITY(PAR_NONE), .STOP_BITS(2), .FIFO_DEPTH(4))
        dut3 (.sys_clk(clk), .sys_rst_n(rst_n), .tx_if(if3), .txd(txd_w[3]), .tx_busy(busy_w[3]));

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_until(input int t);
        for (int k = 0; k < 5000 && cyc < t; k++) @(negedge clk);
    endtask

    // Present a word (valid left high) and wait for acceptance. Called and
    // returns at a falling edge. acc = accept edge, st = expected start cycle.
    task automatic push(input int id, input logic [8:0] d, input logic [12:0] bits,
                        input int nb, output int acc, output int st);
        exp_t e;
        drv_data[id]  = d;
        drv_valid[id] = 1'b1;
        acc = -1;
        for (int k = 0; k < 1000; k++) begin
            if (ready_w[id] === 1'b1) begin
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL dut%0d accept of %03h: no tx_ready within 1000 cycles", id, d);
            st = -1;
            return;
        end
        @(negedge clk);
        st = (acc + 1 > last_end[id]) ? acc + 1 : last_end[id];
        last_end[id] = st + nb * BD;
        e.bits  = bits;
        e.nbits = 4'(nb);
        e.start = 32'(st);
        exp_q[id].push_back(e);
    endtask

    // Frame monitor: on a start bit, pop the expected frame, check its start
    // cycle and every sample of every bit. A reset mid-frame abandons it.
    task automatic monitor(input int id);
        exp_t e;
        int   bad;
        int   nsamp;
        bit   aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && txd_w[id] === 1'b0) begin
                if (exp_q[id].size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL dut%0d unexpected start bit at cycle %0d: got txd=0, expected idle 1", id, cyc);
                    for (int k = 0; k < 200 && txd_w[id] !== 1'b1; k++) @(negedge clk);
                end else begin
                    e = exp_q[id].pop_front();
                    check($sformatf("dut%0d start cycle of frame %03h", id, e.bits), cyc, int'(e.start));
                    nsamp   = int'(e.nbits) * BD;
                    bad     = 0;
                    aborted = 1'b0;
                    for (int k = 0; k < nsamp; k++) begin
                        if (k > 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (txd_w[id] !== e.bits[k / BD]) bad++;
                    end
                    if (!aborted) check($sformatf("dut%0d frame %03h wrong samples", id, e.bits), bad, 0);
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);
    initial monitor(3);

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, st, lows, st_rst;
        int accs [6];
        int sts  [6];
        for (int i = 0; i < 4; i++) begin
            drv_data[i] = '0;
            last_end[i] = 0;
        end

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("dut%0d txd in reset", i), txd_w[i], 1);
            check($sformatf("dut%0d tx_ready in reset", i), ready_w[i], 0);
            check($sformatf("dut%0d tx_busy in reset", i), busy_w[i], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) check($sformatf("dut%0d tx_ready after reset", i), ready_w[i], 1);

        // 8N1, 0x55 into an idle block: 0,1,0,1,... 100 cycles, start at N+1.
        push(0, 9'h055, 13'h2AA, 10, acc, st);
        drv_valid[0] = 1'b0;
        check("dut0 start latency", st, acc + 1);
        wait_until(st + 99);
        check("dut0 tx_busy on last stop cycle", busy_w[0], 1);
        @(negedge clk);
        check("dut0 tx_busy after frame", busy_w[0], 0);
        check("dut0 txd idle after frame", txd_w[0], 1);

        // 8E1 / 8O1 with 0xA3 (parity 0 / 1), 7N2 with 0x7F.
        push(1, 9'h0A3, 13'h546, 11, acc, st);
        drv_valid[1] = 1'b0;
        push(2, 9'h0A3, 13'h746, 11, acc, st);
        drv_valid[2] = 1'b0;
        push(3, 9'h07F, 13'h3FE, 10, acc, st);
        drv_valid[3] = 1'b0;
        wait_until(last_end[2] + 2);
        check("dut1 tx_busy after frame", busy_w[1], 0);
        check("dut2 tx_busy after frame", busy_w[2], 0);
        check("dut3 tx_busy after frame", busy_w[3], 0);

        // Back-to-back with tx_valid held high on the 8N1 block.
`ifdef UART_TX_FIFO_EN
        for (int k = 0; k < 6; k++)
            push(0, 9'(8'h11 + k), 13'(13'h222 + 2 * k), 10, accs[k], sts[k]);
        check("dut0 tx_ready low with fifo full", ready_w[0], 0);
        drv_valid[0] = 1'b0;
        for (int k = 1; k < 5; k++) check($sformatf("dut0 fifo accept %0d edge", k + 1), accs[k], accs[0] + k);
        check("dut0 sixth accept at frame boundary", accs[5], sts[1] + 1);
`else
        push(0, 9'h001, 13'h202, 10, accs[0], sts[0]);
        push(0, 9'h002, 13'h204, 10, accs[1], sts[1]);
        push(0, 9'h003, 13'h206, 10, accs[2], sts[2]);
        check("dut0 tx_ready low with holding reg full", ready_w[0], 0);
        drv_valid[0] = 1'b0;
        check("dut0 second accept edge", accs[1], accs[0] + 2);
        check("dut0 third accept at frame boundary", accs[2], sts[1] + 1);
`endif
        wait_until(last_end[0] + 2);
        check("dut0 tx_busy after burst", busy_w[0], 0);

        // Reset 35 cycles into a 7N2 frame with a second word buffered.
        push(3, 9'h02A, 13'h354, 10, acc, st_rst);
        push(3, 9'h015, 13'h32A, 10, acc, st);
        drv_valid[3] = 1'b0;
        wait_until(st_rst + 34);
        rst_n = 1'b0;
        @(negedge clk);
        check("dut3 txd after mid-frame reset", txd_w[3], 1);
        check("dut3 tx_busy after mid-frame reset", busy_w[3], 0);
        check("dut3 tx_ready during reset", ready_w[3], 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q[3].delete();
        last_end[3] = 0;
        @(negedge clk);
        check("dut3 tx_ready after reset release", ready_w[3], 1);
        check("dut3 tx_busy after reset release", busy_w[3], 0);
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (txd_w[3] !== 1'b1) lows++;
        end
        check("dut3 residual low samples after reset", lows, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter: configurable baud divisor, data width, parity mode and stop-bit count, with a valid/ready input handshake and back-to-back frames with zero idle gap. Successor to the fixed-format `top_UART_TX` in the serial output path. Upstream logic pushes words; the block drives `txd` directly to the pad.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate. `BAUD_DIV = CLK_FREQ/BAUD_RATE`, integer division, must be ≥ 2.
- `DATA_BITS`, 8: payload width, legal 5–9.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop-bit count, legal 1–2.
- `FIFO_DEPTH`, 16: FIFO entries, power of two ≥ 2. Used only with `UART_TX_FIFO_EN`.
- `sys_clk` in 1: system clock, all logic on the rising edge.
- `sys_rst_n` in 1: reset, synchronous, active-low.
- `tx_data` in DATA_BITS: word to send, sent LSB first.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: block can accept a word this cycle.
- `txd` out 1: serial line, registered, idles high.
- `tx_busy` out 1: a frame is in flight or a word is buffered.

## Operation
- A word is accepted on a rising edge where `tx_valid && tx_ready`.
  - The word goes into the buffer: a 1-entry holding register, or the FIFO.
  - `tx_valid` may drop or `tx_data` may change after acceptance with no effect.
- FSM states: IDLE, START, DATA, PAR, STOP.
- Baud counter counts 0..BAUD_DIV-1. Each bit is held exactly BAUD_DIV cycles.
- IDLE: `txd`=1. If the buffer is non-empty, pop it into the shifter and go to START.
- START: `txd`=0 for one bit period, then go to DATA.
- DATA: shift out DATA_BITS bits, LSB first. Then go to PAR if PARITY≠0, else STOP.
- PAR: odd mode makes the ones count of data plus parity odd; even mode makes it even.
- STOP: `txd`=1 for STOP_BITS bit periods.
  - On the last cycle of the last stop bit: if the buffer is non-empty, pop it and go directly to START (zero gap). Otherwise go to IDLE.
- `tx_ready` = buffer not full AND `sys_rst_n`.
- Accept and pop in the same cycle are both honoured. Occupancy stays unchanged.
- `tx_busy` = (state≠IDLE) OR buffer non-empty.

## Timing
- Reset values: `txd`=1, `tx_ready`=0 while `sys_rst_n`=0, `tx_busy`=0. State is IDLE, the buffer is empty, counters are 0.
- Reset is honoured mid-frame: `txd`=1 from the next edge. The frame is aborted and buffered words are discarded.
- Frame length: F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BAUD_DIV cycles.
- Latency, idle block: accept at edge N, pop at edge N+1, `txd`=0 from edge N+1.
- Back-to-back: the next start bit begins on the edge immediately after the final stop-bit cycle.
- Illegal parameters (BAUD_DIV<2, DATA_BITS outside 5–9, STOP_BITS outside 1–2) stop elaboration via a generate-time error.

## Configuration
- `UART_TX_FIFO_EN` defined: the buffer is a FIFO_DEPTH-entry FIFO.
  - `tx_ready` falls only when FIFO_DEPTH words are buffered beyond the one in the shifter.
- `UART_TX_FIFO_EN` undefined: the buffer is a single holding register; FIFO_DEPTH is ignored.
  - At most one word is buffered while a frame is in flight.

## Structure
- Package `uart_pkg`:
  - Parity-mode constants (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`).
  - FSM state typedef.
  - Baud-divisor calculation function.
- Sub-module `uart_tx_fifo`: synchronous FIFO with push/pop, full/empty flags and wrap-around pointers. Instantiated only under `UART_TX_FIFO_EN`.

## Test plan
All scenarios use CLK_FREQ=50_000_000 and BAUD_RATE=5_000_000, so BAUD_DIV=10.
- 8N1, push 0x55 while idle:
  - `txd` = 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles.
  - Frame is 100 cycles, start bit from edge N+1.
  - `tx_busy` drops at the cycle after the frame ends.
- 8E1 and 8O1, push 0xA3 (four ones): parity bit is 0 for even and 1 for odd. Frame is 110 cycles.
- 7 data bits, no parity, 2 stop bits, push 0x7F: data bits all 1, then 20 cycles of stop. Frame is 100 cycles.
- Push 0x01 and 0x02 with `tx_valid` held high:
  - Second start bit begins exactly 100 cycles after the first start bit. `txd` never goes high between frames beyond the stop bits.
  - Without FIFO: exactly 2 words accepted, then `tx_ready`=0 until the first pop at frame end.
  - With FIFO (FIFO_DEPTH=4): push 6 words continuously. Words 1–5 are accepted, then `tx_ready`=0. `tx_ready` rises for one accept at each frame boundary. All 6 words are sent in order with no gaps.
- Assert reset at cycle 35 of a frame:
  - `txd`=1 on the next edge; `tx_busy`=0.
  - After release, `tx_ready`=1 and no residual bits are sent.
